// File: rtl/popcount_pkg.sv
// Shared types and helpers for the sequential population-count unit.
// Any block that needs to decode popcount state or count a group of bits imports this package.
package popcount_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Widest STEP group the helper can count, and the width of its result.
  localparam int MAX_STEP = 64;
  localparam int STEP_CW  = $clog2(MAX_STEP + 1);

  // Callers zero-extend their STEP-bit group to MAX_STEP bits.
  // The unused high bits are constant zero, so synthesis trims them away.
  function automatic logic [STEP_CW-1:0] popcount_step(input logic [MAX_STEP-1:0] grp);
    logic [STEP_CW-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_STEP; i++) begin
      n = n + STEP_CW'(grp[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/popcount_seq_cntlr.sv
// Controller for popcount_seq: holds the state register and decodes the
// datapath strobes and the handshake outputs from the current state.
module popcount_seq_cntlr
  import popcount_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic start,
  input  logic abort,
  input  logic ack,
  input  logic zero,
  output logic load_regs,
  output logic count_and_shift,
  output logic clear,
  output logic rdy,
  output logic busy,
  output logic result_valid
);

  state_t state, state_nxt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_nxt       = state;
    load_regs       = 1'b0;
    count_and_shift = 1'b0;
    clear           = 1'b0;
    rdy             = 1'b0;
    busy            = 1'b0;
    result_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        rdy = 1'b1;
        if (start) begin
          load_regs = 1'b1;
          state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        busy = 1'b1;
        if (abort) begin
          clear     = 1'b1;
          state_nxt = S_IDLE;
        end else if (zero) begin
          state_nxt = S_DONE;
        end else begin
          count_and_shift = 1'b1;
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (ack) begin
          state_nxt = S_IDLE;
        end
      end
      // The unused encoding deasserts every output and goes back to idle.
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/popcount_seq.sv
// Sequential population count: examines STEP bits per cycle from the MSB and stops
// early once the shifted word is zero. The count is held until ack.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int STEP  = 1,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             abort,
  input  logic             ack,
  output logic             rdy,
  output logic             busy,
  output logic             result_valid,
  output logic [CW-1:0]    count
);

  if (WIDTH < 2 || STEP < 1 || STEP > MAX_STEP || (WIDTH % STEP) != 0) begin : g_bad_params
    $error("popcount_seq: WIDTH must be >= 2 and a multiple of STEP (1..MAX_STEP)");
  end

  logic [WIDTH-1:0]    shreg;
  logic [MAX_STEP-1:0] grp_ext;
  logic [CW-1:0]       grp_cnt;
  logic                zero;
  logic                load_regs;
  logic                count_and_shift;
  logic                clear;

  assign zero = (shreg == '0);

  always_comb begin
    grp_ext            = '0;
    grp_ext[STEP-1:0]  = shreg[WIDTH-1 -: STEP];
  end

  // A single group holds at most STEP <= WIDTH ones, so its count always fits in CW bits.
  assign grp_cnt = CW'(popcount_step(grp_ext));

  popcount_seq_cntlr u_cntlr (
    .clk             (clk),
    .rst_b           (rst_b),
    .start           (start),
    .abort           (abort),
    .ack             (ack),
    .zero            (zero),
    .load_regs       (load_regs),
    .count_and_shift (count_and_shift),
    .clear           (clear),
    .rdy             (rdy),
    .busy            (busy),
    .result_valid    (result_valid)
  );

  // NOTE: shreg and count are plain registers, not a memory, so both get the async reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      shreg <= '0;
      count <= '0;
    end else if (clear) begin
      shreg <= '0;
      count <= '0;
    end else if (load_regs) begin
      shreg <= data_in;
      count <= '0;
    end else if (count_and_shift) begin
      shreg <= shreg << STEP;
      count <= count + grp_cnt;
    end
  end

endmodule

// File: tb/tb_popcount_seq.sv
// Scoreboarded bench for popcount_seq at WIDTH=8/STEP=1 and WIDTH=16/STEP=4.
// An independent model predicts count and latency; results are compared when result_valid rises.
module tb_popcount_seq;

  typedef struct {
    int cnt;
    int lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ack = 1'b0;
  logic        sel16 = 1'b0;
  logic [15:0] data = '0;

  logic       start8, start16;
  logic       rdy8, busy8, rv8;
  logic       rdy16, busy16, rv16;
  logic [3:0] cnt8;
  logic [4:0] cnt16;
  logic       rdy, busy, rv;
  logic [4:0] cnt;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_cnt = 0;

  assign start8  = start & ~sel16;
  assign start16 = start & sel16;
  assign rdy  = sel16 ? rdy16  : rdy8;
  assign busy = sel16 ? busy16 : busy8;
  assign rv   = sel16 ? rv16   : rv8;
  assign cnt  = sel16 ? cnt16  : {1'b0, cnt8};

  popcount_seq #(.WIDTH(8), .STEP(1)) dut8 (
    .clk          (clk),
    .rst_b        (rst_b),
    .start        (start8),
    .data_in      (data[7:0]),
    .abort        (abort),
    .ack          (ack),
    .rdy          (rdy8),
    .busy         (busy8),
    .result_valid (rv8),
    .count        (cnt8)
  );

  popcount_seq #(.WIDTH(16), .STEP(4)) dut16 (
    .clk          (clk),
    .rst_b        (rst_b),
    .start        (start16),
    .data_in      (data),
    .abort        (abort),
    .ack          (ack),
    .rdy          (rdy16),
    .busy         (busy16),
    .result_valid (rv16),
    .count        (cnt16)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected count is the number of ones. Latency is g+1 edges, where g is the
  // 1-based index (from the MSB) of the lowest-order group that holds a 1.
  function automatic exp_t model(input logic [15:0] d, input int w, input int s);
    exp_t e;
    int   g;
    e.cnt = 0;
    g     = 0;
    for (int i = 0; i < w / s; i++) begin
      int ones;
      ones = 0;
      for (int b = 0; b < s; b++) begin
        ones += int'(d[w - 1 - i * s - b]);
      end
      if (ones != 0) g = i + 1;
      e.cnt += ones;
    end
    e.lat = g + 1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, then wait for result_valid and score it against the queue.
  task automatic launch_and_wait(input logic [15:0] d);
    exp_t e;
    int   k;
    bit   done;
    check("rdy_before_start", int'(rdy), 1);
    start = 1'b1;
    data  = d;
    sb_q.push_back(model(d, sel16 ? 16 : 8, sel16 ? 4 : 1));
    tick();
    start = 1'b0;
    k     = 0;
    done  = 1'b0;
    while (!done && k < 64) begin
      tick();
      k++;
      if (rv) done = 1'b1;
      else check("busy_while_counting", int'(busy), 1);
    end
    e = sb_q.pop_front();
    if (!done) begin
      check("result_valid_timeout", 0, 1);
    end else begin
      check("latency", k, e.lat);
      check("count", int'(cnt), e.cnt);
    end
    last_cnt = e.cnt;
  endtask

  // Hold the result for a few cycles without ack, then acknowledge it.
  task automatic finish(input int hold);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("result_held", int'(rv), 1);
      check("count_held", int'(cnt), last_cnt);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("rv_drop_after_ack", int'(rv), 0);
    check("rdy_after_ack", int'(rdy), 1);
    check("count_kept_in_idle", int'(cnt), last_cnt);
  endtask

  task automatic run_op(input logic [15:0] d, input int hold);
    launch_and_wait(d);
    finish(hold);
  endtask

  initial begin
    bit seen_rv;

    #12;
    check("reset_rdy", int'(rdy), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_rv", int'(rv), 0);
    check("reset_count", int'(cnt), 0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    // 8-bit, one bit per cycle.
    sel16 = 1'b0;
    run_op(16'h00B0, 3);
    run_op(16'h0000, 0);
    run_op(16'h00FF, 0);

    // 16-bit, four bits per cycle.
    sel16 = 1'b1;
    run_op(16'h8001, 0);
    run_op(16'hF000, 0);
    sel16 = 1'b0;

    // Abort in the third S_COUNT cycle of 8'hFF.
    start = 1'b1;
    data  = 16'h00FF;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rdy", int'(rdy), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_count", int'(cnt), 0);
    seen_rv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rv) seen_rv = 1'b1;
      tick();
    end
    check("abort_no_result", int'(seen_rv), 0);

    // Abort and start are both ignored in S_DONE.
    launch_and_wait(16'h000F);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_done_rv", int'(rv), 1);
    check("abort_in_done_count", int'(cnt), last_cnt);
    start = 1'b1;
    data  = 16'h00AA;
    tick();
    start = 1'b0;
    check("start_in_done_rv", int'(rv), 1);
    check("start_in_done_count", int'(cnt), last_cnt);
    check("start_in_done_rdy", int'(rdy), 0);
    finish(0);
    run_op(16'h0001, 0);

    // Asynchronous reset in the middle of counting.
    start = 1'b1;
    data  = 16'h00FF;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_b = 1'b0;
    #1;
    check("async_rst_rdy", int'(rdy), 1);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_rv", int'(rv), 0);
    check("async_rst_count", int'(cnt), 0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    run_op(16'h0080, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
